tick_rate_meter: RTL and testbench
==================================

// Module: tick_rate_meter
// PURPOSE
//  Receive-side partner of clkscaler: measures how many inc_clk rising edges occur
//  per ref_clk period, so the scaled increment rate is checked in-system against the
//  selected trigger setting. Sits directly after clkscaler, in the same clk domain.
//  Delivers one result per complete window over a valid/ready handshake and flags
//  saturation and overrun.
// PARAMETERS
//  CNT_WIDTH  19   width of the window counter and of meas_count
//  EXP_WIDTH  19   width of exp_count (must equal CNT_WIDTH)
//  TOL        2    +/- tolerance, in edges, for in_range
// PORTS
//  clk         in   1          system clock; all logic is on its rising edge
//  reset       in   1          asynchronous, active-high reset
//  enable      in   1          1 = measure; 0 = abort and return to IDLE
//  inc_clk     in   1          increment strobe from clkscaler (level; rising edges counted)
//  ref_clk     in   1          reference tick from clkscaler (rising edge = window boundary)
//  exp_count   in   EXP_WIDTH  expected edges per window; sampled when a window closes
//  meas_count  out  CNT_WIDTH  edges counted in the last completed window
//  meas_valid  out  1          meas_count/in_range/sat valid
//  meas_ready  in   1          consumer accepts the result when valid&&ready
//  sat         out  1          window count saturated at all-ones
//  in_range    out  1          |meas_count - exp_count| <= TOL
//  overrun     out  1          sticky: a result was dropped; cleared by reset or !enable
// BEHAVIOUR
//  - Reset (async assert, sync deassert by the system): state=IDLE. All outputs 0,
//    edge registers 0, window counter 0.
//  - Edge detect: inc_q/ref_q are 1-cycle delayed copies.
//    inc_rise = inc_clk & ~inc_q. ref_rise = ref_clk & ~ref_q.
//    Inputs are same-domain; no synchronisers.
//  - States: IDLE -> ARMED when enable=1.
//    ARMED: counter held 0, inc edges ignored. First ref_rise -> COUNT.
//    COUNT: each inc_rise increments the counter; it saturates at 2^CNT_WIDTH-1 and
//    sets the internal sat flag. On ref_rise the window closes: the result is latched
//    and the counter restarts at 0 (1 if inc_rise in the same cycle).
//    Stays in COUNT.
//  - Simultaneous inc_rise and ref_rise: the edge belongs to the NEW window.
//  - Result latch (cycle after the closing ref_rise): meas_count <= counter,
//    sat <= sat flag, in_range <= range compare vs exp_count, meas_valid <= 1.
//    Latency: ref_rise at edge N -> meas_valid high after edge N+1.
//  - Range compare: unsigned difference computed at CNT_WIDTH+1 bits, no wrap.
//    A saturated result forces in_range=0.
//  - Handshake: meas_valid stays high, outputs stable, until valid&&ready.
//    Then meas_valid drops next cycle unless a new result latches that same cycle.
//    In that case valid stays 1 with the new data.
//  - Window closes while meas_valid=1 and !meas_ready: newer result overwrites.
//    overrun <= 1 (sticky).
//  - enable=0 in any state: next cycle state=IDLE; counter, meas_valid, sat, in_range
//    and overrun cleared; meas_count holds its value. Re-enable re-arms, so the first
//    partial window is always discarded.
//  - ref_clk with no inc edges: meas_count=0, valid result.
//    Continuous ref_clk high: no further windows.
// STRUCTURE
//  - Shared package (counter_pkg): state encoding IDLE=2'd0, ARMED=2'd1, COUNT=2'd2;
//    CNT_WIDTH default constant shared with clkscaler.
//  - One sub-module: edge_rise_det (1-bit reg + AND), instantiated for inc_clk
//    and for ref_clk.
//  - Remaining FSM, saturating counter, compare and result register stay inline.
// TESTING
//  T1 basic: enable=1; ref_clk 1-cycle pulse every 100 clk; inc_clk pulse every
//     4 clk; exp_count=25; ready=1 -> meas_count=25, in_range=1, sat=0, overrun=0
//     each window. First partial window not reported.
//  T2 coincidence: align one inc pulse with each ref pulse, 10 inc/window ->
//     meas_count=10 every window, never 9 or 11.
//  T3 backpressure: ready=0 for 3 windows with counts 5,6,7 -> meas_valid held,
//     meas_count=7, overrun=1. ready=1 -> valid drops 1 cycle later.
//  T4 saturation (CNT_WIDTH=4): 20 inc edges/window -> meas_count=15, sat=1,
//     in_range=0.
//  T5 abort: enable=0 mid-window for 1 cycle -> state IDLE, meas_valid=0, overrun=0.
//     Re-enable: next result only after two ref edges.
//  T6 reset: assert reset asynchronously mid-COUNT (between clk edges) -> all
//     outputs 0 immediately. With clkscaler instantiated (REF=12000, trigger=6'b000100):
//     meas_count constant across windows and matching the clkscaler model value.

Source files
------------

// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared state encoding and counter width for the tick measurement path
// Purpose: state encoding and default counter width used by clkscaler and tick_rate_meter.
// Ports: none (package).
package counter_pkg;

  // Default window-counter width, shared with clkscaler.
  localparam int CNT_WIDTH_DEF = 19;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_COUNT = 2'd2
  } state_e;

endpackage

// File: rtl/edge_rise_det.sv
// rtl/edge_rise_det.sv - single-bit rising-edge detector
// Purpose: one-cycle delayed copy of a same-domain level and its rising-edge pulse.
// Ports:
//   clk    in  system clock
//   reset  in  asynchronous active-high reset
//   sig_i  in  level to watch
//   rise_o out high for the cycle in which sig_i is 1 and was 0 the cycle before
module edge_rise_det (
  input  logic clk,
  input  logic reset,
  input  logic sig_i,
  output logic rise_o
);

  logic sig_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sig_q <= 1'b0;
    end else begin
      sig_q <= sig_i;
    end
  end

  assign rise_o = sig_i & ~sig_q;

endmodule

// File: rtl/tick_rate_meter.sv
// rtl/tick_rate_meter.sv - counts inc_clk rising edges per ref_clk window
// Purpose: measures inc_clk rising edges between consecutive ref_clk rising edges and
//          delivers each completed window over a valid/ready handshake, with
//          saturation, tolerance check against exp_count, and a sticky overrun flag.
// Ports:
//   clk        in  system clock
//   reset      in  asynchronous active-high reset
//   enable     in  1 = measure, 0 = abort to IDLE
//   inc_clk    in  increment strobe level (rising edges counted)
//   ref_clk    in  reference tick level (rising edge = window boundary)
//   exp_count  in  expected edges per window, sampled when a window closes
//   meas_count out edges counted in the last completed window
//   meas_valid out result valid
//   meas_ready in  consumer accepts the result when valid && ready
//   sat        out result saturated at all-ones
//   in_range   out |meas_count - exp_count| <= TOL and not saturated
//   overrun    out sticky: an unaccepted result was overwritten
import counter_pkg::*;

module tick_rate_meter #(
  parameter int CNT_WIDTH = CNT_WIDTH_DEF,
  parameter int EXP_WIDTH = CNT_WIDTH_DEF,
  parameter int TOL       = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 inc_clk,
  input  logic                 ref_clk,
  input  logic [EXP_WIDTH-1:0] exp_count,
  output logic [CNT_WIDTH-1:0] meas_count,
  output logic                 meas_valid,
  input  logic                 meas_ready,
  output logic                 sat,
  output logic                 in_range,
  output logic                 overrun
);

  localparam logic [CNT_WIDTH:0]   TOL_V = (CNT_WIDTH+1)'(TOL);
  localparam logic [CNT_WIDTH-1:0] ONE   = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] ZERO  = '0;

  logic inc_rise;
  logic ref_rise;

  edge_rise_det u_inc_det (
    .clk    (clk),
    .reset  (reset),
    .sig_i  (inc_clk),
    .rise_o (inc_rise)
  );

  edge_rise_det u_ref_det (
    .clk    (clk),
    .reset  (reset),
    .sig_i  (ref_clk),
    .rise_o (ref_rise)
  );

  state_e                 state_q, state_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic                   ovf_q, ovf_d;
  // Closing snapshot: held one cycle so the result appears the cycle after ref_rise.
  logic                   pend_q, pend_d;
  logic [CNT_WIDTH-1:0]   pend_cnt_q, pend_cnt_d;
  logic                   pend_sat_q, pend_sat_d;
  logic [EXP_WIDTH-1:0]   pend_exp_q, pend_exp_d;
  logic [CNT_WIDTH-1:0]   meas_count_q, meas_count_d;
  logic                   meas_valid_q, meas_valid_d;
  logic                   sat_q, sat_d;
  logic                   in_range_q, in_range_d;
  logic                   overrun_q, overrun_d;

  logic [CNT_WIDTH:0]     a_ext, b_ext, diff;
  logic [CNT_WIDTH-1:0]   restart_val;

  // One extra bit so the difference never wraps.
  assign a_ext = {1'b0, pend_cnt_q};
  assign b_ext = (CNT_WIDTH+1)'(pend_exp_q);
  assign diff  = (a_ext >= b_ext) ? (a_ext - b_ext) : (b_ext - a_ext);

  // An inc edge coinciding with the boundary belongs to the new window.
  assign restart_val = inc_rise ? ONE : ZERO;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    ovf_d        = ovf_q;
    pend_d       = 1'b0;
    pend_cnt_d   = pend_cnt_q;
    pend_sat_d   = pend_sat_q;
    pend_exp_d   = pend_exp_q;
    meas_count_d = meas_count_q;
    meas_valid_d = meas_valid_q;
    sat_d        = sat_q;
    in_range_d   = in_range_q;
    overrun_d    = overrun_q;

    // Result register; a new result wins over a same-cycle handshake.
    if (pend_q) begin
      meas_count_d = pend_cnt_q;
      sat_d        = pend_sat_q;
      in_range_d   = !pend_sat_q && (diff <= TOL_V);
      meas_valid_d = 1'b1;
      if (meas_valid_q && !meas_ready) begin
        overrun_d = 1'b1;
      end
    end else if (meas_valid_q && meas_ready) begin
      meas_valid_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        cnt_d   = ZERO;
        ovf_d   = 1'b0;
        state_d = ST_ARMED;
      end
      ST_ARMED: begin
        cnt_d = ZERO;
        ovf_d = 1'b0;
        if (ref_rise) begin
          state_d = ST_COUNT;
          cnt_d   = restart_val;
        end
      end
      ST_COUNT: begin
        if (ref_rise) begin
          pend_d     = 1'b1;
          pend_cnt_d = cnt_q;
          pend_sat_d = ovf_q;
          pend_exp_d = exp_count;
          cnt_d      = restart_val;
          ovf_d      = 1'b0;
        end else if (inc_rise) begin
          if (&cnt_q) begin
            ovf_d = 1'b1;
          end else begin
            cnt_d = cnt_q + ONE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Abort: everything but meas_count returns to its idle value.
    if (!enable) begin
      state_d      = ST_IDLE;
      cnt_d        = ZERO;
      ovf_d        = 1'b0;
      pend_d       = 1'b0;
      meas_valid_d = 1'b0;
      sat_d        = 1'b0;
      in_range_d   = 1'b0;
      overrun_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      ovf_q        <= 1'b0;
      pend_q       <= 1'b0;
      pend_cnt_q   <= '0;
      pend_sat_q   <= 1'b0;
      pend_exp_q   <= '0;
      meas_count_q <= '0;
      meas_valid_q <= 1'b0;
      sat_q        <= 1'b0;
      in_range_q   <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ovf_q        <= ovf_d;
      pend_q       <= pend_d;
      pend_cnt_q   <= pend_cnt_d;
      pend_sat_q   <= pend_sat_d;
      pend_exp_q   <= pend_exp_d;
      meas_count_q <= meas_count_d;
      meas_valid_q <= meas_valid_d;
      sat_q        <= sat_d;
      in_range_q   <= in_range_d;
      overrun_q    <= overrun_d;
    end
  end

  assign meas_count = meas_count_q;
  assign meas_valid = meas_valid_q;
  assign sat        = sat_q;
  assign in_range   = in_range_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_tick_rate_meter.sv
// tb/tb_tick_rate_meter.sv - directed self-checking bench for tick_rate_meter
module tb_tick_rate_meter;

  logic        clk;
  logic        reset;
  logic        enable;
  logic        inc_clk;
  logic        ref_clk;
  logic [18:0] exp_count;
  logic [3:0]  exp4;
  logic        meas_ready;

  logic [18:0] meas_count;
  logic        meas_valid, sat, in_range, overrun;
  logic [3:0]  meas_count4;
  logic        meas_valid4, sat4, in_range4, overrun4;

  int total = 0;
  int bad   = 0;

  int   rc_cnt [8];
  logic rc_ir  [8];
  logic rc_sat [8];
  int   nres;

  tick_rate_meter dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .inc_clk    (inc_clk),
    .ref_clk    (ref_clk),
    .exp_count  (exp_count),
    .meas_count (meas_count),
    .meas_valid (meas_valid),
    .meas_ready (meas_ready),
    .sat        (sat),
    .in_range   (in_range),
    .overrun    (overrun)
  );

  tick_rate_meter #(.CNT_WIDTH(4), .EXP_WIDTH(4), .TOL(2)) dut4 (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .inc_clk    (inc_clk),
    .ref_clk    (ref_clk),
    .exp_count  (exp4),
    .meas_count (meas_count4),
    .meas_valid (meas_valid4),
    .meas_ready (meas_ready),
    .sat        (sat4),
    .in_range   (in_range4),
    .overrun    (overrun4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, want);
    end
  endtask

  // Called at a negedge: logs a handshake that the coming posedge will complete,
  // then applies new levels and advances one cycle.
  task automatic drive(input logic r, input logic i);
    if (meas_valid && meas_ready) begin
      if (nres < 8) begin
        rc_cnt[nres] = int'(meas_count);
        rc_ir[nres]  = in_range;
        rc_sat[nres] = sat;
      end
      nres++;
    end
    ref_clk = r;
    inc_clk = i;
    @(negedge clk);
  endtask

  task automatic ref_pulse();
    drive(1'b1, 1'b0);
    drive(1'b0, 1'b0);
  endtask

  task automatic inc_pulses(input int n);
    for (int j = 0; j < n; j++) begin
      drive(1'b0, 1'b1);
      drive(1'b0, 1'b0);
    end
  endtask

  task automatic run_pattern(input int ncyc, input int rp, input int rph, input int ip, input int iph);
    for (int k = 0; k < ncyc; k++) begin
      drive(logic'((k % rp) == rph), logic'((k % ip) == iph));
    end
    drive(1'b0, 1'b0);
  endtask

  task automatic abort_rearm();
    enable = 1'b0;
    drive(1'b0, 1'b0);
    enable = 1'b1;
    drive(1'b0, 1'b0);
    nres = 0;
  endtask

  task automatic check_results(input string tag, input int n, input int cnt, input logic ir);
    check({tag, "_nres"}, nres, n);
    for (int j = 0; j < n && j < 8; j++) begin
      check({tag, "_cnt"}, rc_cnt[j], cnt);
      check({tag, "_inr"}, 32'(rc_ir[j]), 32'(ir));
      check({tag, "_sat"}, 32'(rc_sat[j]), 0);
    end
  endtask

  initial begin
    reset      = 1'b1;
    enable     = 1'b0;
    inc_clk    = 1'b0;
    ref_clk    = 1'b0;
    exp_count  = '0;
    exp4       = '0;
    meas_ready = 1'b1;
    nres       = 0;

    repeat (3) @(negedge clk);
    check("rst_valid", meas_valid, 0);
    check("rst_count", meas_count, 0);
    check("rst_flags", {sat, in_range, overrun}, 0);
    reset = 1'b0;
    drive(1'b0, 1'b0);

    // T1: ref every 100, inc every 4 -> 25 per window, partial window dropped
    exp_count = 19'd25;
    enable = 1'b1;
    drive(1'b0, 1'b0);
    nres = 0;
    run_pattern(400, 100, 50, 4, 1);
    check_results("t1", 3, 25, 1'b1);
    check("t1_overrun", overrun, 0);

    // T2: inc coincident with ref, 10 per window; exp 12 sits at the tolerance edge
    abort_rearm();
    exp_count = 19'd12;
    run_pattern(160, 50, 0, 5, 0);
    check_results("t2", 3, 10, 1'b1);

    // Latency: ref_rise at edge N -> valid after N+1; diff 3 is out of range
    abort_rearm();
    exp_count = 19'd0;
    ref_pulse();
    inc_pulses(3);
    drive(1'b1, 1'b0);
    check("lat_n", meas_valid, 0);
    drive(1'b0, 1'b0);
    check("lat_n1", meas_valid, 1);
    check("lat_cnt", meas_count, 3);
    check("lat_inr", in_range, 0);

    // T3: backpressure over windows of 5,6,7
    meas_ready = 1'b0;
    abort_rearm();
    exp_count = 19'd9;
    ref_pulse();
    inc_pulses(5);
    ref_pulse();
    inc_pulses(6);
    ref_pulse();
    inc_pulses(7);
    ref_pulse();
    check("t3_valid", meas_valid, 1);
    check("t3_cnt", meas_count, 7);
    check("t3_overrun", overrun, 1);
    check("t3_inr", in_range, 1);
    check("t3_nres", nres, 0);
    meas_ready = 1'b1;
    drive(1'b0, 1'b0);
    check("t3_drop", meas_valid, 0);
    check("t3_taken", nres, 1);
    check("t3_taken_cnt", rc_cnt[0], 7);
    check("t3_sticky", overrun, 1);

    // T4: 20 edges into a 4-bit counter saturates; the wide instance does not
    abort_rearm();
    exp_count = 19'd20;
    exp4 = 4'd15;
    ref_pulse();
    inc_pulses(20);
    ref_pulse();
    check("t4_valid4", meas_valid4, 1);
    check("t4_cnt4", meas_count4, 15);
    check("t4_sat4", sat4, 1);
    check("t4_inr4", in_range4, 0);
    check("t4_cnt", meas_count, 20);
    check("t4_sat", sat, 0);
    check("t4_inr", in_range, 1);

    // T5: abort clears state; first window after re-enable is discarded
    meas_ready = 1'b0;
    abort_rearm();
    exp_count = 19'd3;
    ref_pulse();
    inc_pulses(3);
    ref_pulse();
    inc_pulses(2);
    ref_pulse();
    check("t5_overrun_set", overrun, 1);
    enable = 1'b0;
    drive(1'b0, 1'b0);
    check("t5_valid", meas_valid, 0);
    check("t5_overrun", overrun, 0);
    check("t5_hold", meas_count, 2);
    enable = 1'b1;
    drive(1'b0, 1'b0);
    inc_pulses(2);
    ref_pulse();
    inc_pulses(4);
    drive(1'b0, 1'b0);
    check("t5_no_partial", meas_valid, 0);
    ref_pulse();
    check("t5_valid2", meas_valid, 1);
    check("t5_cnt2", meas_count, 4);

    // T6: asynchronous reset between clock edges mid-COUNT
    inc_pulses(1);
    ref_pulse();
    inc_pulses(5);
    check("t6_pre_overrun", overrun, 1);
    check("t6_pre_inr", in_range, 1);
    #2 reset = 1'b1;
    #1;
    check("t6_count", meas_count, 0);
    check("t6_valid", meas_valid, 0);
    check("t6_flags", {sat, in_range, overrun}, 0);
    @(negedge clk);
    reset = 1'b0;
    meas_ready = 1'b1;
    nres = 0;
    drive(1'b0, 1'b0);
    ref_pulse();
    inc_pulses(2);
    ref_pulse();
    check("t6_after_valid", meas_valid, 1);
    check("t6_after_cnt", meas_count, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
